// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the
// single-port 1024x10 memory. The arbiter takes the slave view; the
// requester/memory side takes the master view.
interface mem_arbiter_if;
  // instruction-fetch port
  logic       f_req;
  logic [9:0] f_addr;
  logic       f_gnt;
  logic [9:0] f_rdata;
  logic       f_valid;
  // data load/store port
  logic       d_req;
  logic       d_we;
  logic [9:0] d_addr;
  logic [9:0] d_wdata;
  logic       d_gnt;
  logic [9:0] d_rdata;
  logic       d_valid;
  // fetch stall
  logic       halt;
  // memory side
  logic [9:0] mem_addr;
  logic [9:0] mem_wdata;
  logic       mem_we;
  logic [9:0] mem_rdata;

  modport slave (
    input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, halt, mem_rdata,
    output f_gnt, f_rdata, f_valid, d_gnt, d_rdata, d_valid,
           mem_addr, mem_wdata, mem_we
  );

  modport master (
    output f_req, f_addr, d_req, d_we, d_addr, d_wdata, halt, mem_rdata,
    input  f_gnt, f_rdata, f_valid, d_gnt, d_rdata, d_valid,
           mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a single-port memory. Data accesses win by
// default; a waiting fetch is forced through after STARVE_LIMIT consecutive
// data grants. Grant in cycle N, memory access in N+1, valid pulse in N+2.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 3
) (
  input  logic clk,
  input  logic reset_n,
  mem_arbiter_if.slave bus
);

  // The state names the owner of the memory cycle currently on the bus.
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;

  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);

  logic [1:0]    state_reg;
  logic [CW-1:0] starve_cnt_reg;
  logic [CW-1:0] starve_cnt_next;
  logic [9:0]    mem_addr_reg;
  logic [9:0]    mem_wdata_reg;
  logic          mem_we_reg;
  logic [9:0]    f_rdata_reg;
  logic [9:0]    d_rdata_reg;
  logic          f_valid_reg;
  logic          d_valid_reg;

  logic fetch_ok;
  logic fetch_starved;
  logic f_gnt_c;
  logic d_gnt_c;

  // Grant decision: data first unless a starved, unhalted fetch is waiting.
  // Grants are held off while reset is asserted so every output reads 0.
  always_comb begin
    fetch_ok      = bus.f_req && !bus.halt && reset_n;
    fetch_starved = fetch_ok && (starve_cnt_reg == LIMIT_C);
    d_gnt_c       = bus.d_req && reset_n && !fetch_starved;
    f_gnt_c       = fetch_ok && !d_gnt_c;
  end

  // Starve count: counts data grants that passed over a waiting fetch.
  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    if (!bus.f_req || f_gnt_c) begin
      starve_cnt_next = '0;
    end else if (d_gnt_c && (starve_cnt_reg != LIMIT_C)) begin
      starve_cnt_next = starve_cnt_reg + CW'(1);
    end
  end

  // Latch the granted request onto the memory bus for the next cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      starve_cnt_reg <= '0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
      mem_we_reg     <= 1'b0;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
      mem_we_reg     <= d_gnt_c && bus.d_we;
      if (d_gnt_c) begin
        state_reg     <= DATA;
        mem_addr_reg  <= bus.d_addr;
        mem_wdata_reg <= bus.d_wdata;
      end else if (f_gnt_c) begin
        state_reg    <= FETCH;
        mem_addr_reg <= bus.f_addr;
      end else begin
        // no owner: address and write data hold, write enable drops
        state_reg <= IDLE;
      end
    end
  end

  // Capture read data at the end of the access cycle and pulse the owner's valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      f_rdata_reg <= '0;
      d_rdata_reg <= '0;
      f_valid_reg <= 1'b0;
      d_valid_reg <= 1'b0;
    end else begin
      f_valid_reg <= (state_reg == FETCH);
      d_valid_reg <= (state_reg == DATA);
      if (state_reg == FETCH) begin
        f_rdata_reg <= bus.mem_rdata;
      end
      // stores complete with a valid pulse but leave load data untouched
      if ((state_reg == DATA) && !mem_we_reg) begin
        d_rdata_reg <= bus.mem_rdata;
      end
    end
  end

  assign bus.f_gnt     = f_gnt_c;
  assign bus.d_gnt     = d_gnt_c;
  assign bus.f_rdata   = f_rdata_reg;
  assign bus.f_valid   = f_valid_reg;
  assign bus.d_rdata   = d_rdata_reg;
  assign bus.d_valid   = d_valid_reg;
  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_wdata = mem_wdata_reg;
  assign bus.mem_we    = mem_we_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by
// random requester traffic, all compared against a transaction-level model.
module tb_mem_arbiter;
  localparam int LIMIT = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if bus();

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // memory device seen by the DUT, and the model's own view of memory
  logic [9:0] mem     [1024];
  logic [9:0] ref_mem [1024];
  assign bus.mem_rdata = mem[bus.mem_addr];

  int checks = 0;
  int errors = 0;
  int we_cycles = 0;

  // model state: access in flight this cycle (s1) and completing this cycle (s2)
  int         cnt = 0;
  logic       s1_v = 1'b0, s1_f = 1'b0, s1_we = 1'b0;
  logic [9:0] s1_a = '0, s1_wd = '0;
  logic       s2_v = 1'b0, s2_f = 1'b0;
  logic [9:0] f_rd = '0, d_rd = '0, last_addr = '0;
  logic       last_fg = 1'b0, last_dg = 1'b0;

  // snapshots taken at the falling edge
  logic       obs_fg, obs_dg, obs_fv, obs_dv, obs_we;
  logic [9:0] obs_frd, obs_drd, obs_maddr, obs_mwd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: compare DUT against the model mid-cycle, then advance the model.
  task automatic step();
    logic fw, exp_fg, exp_dg;
    @(negedge clk);
    obs_fg = bus.f_gnt;   obs_dg = bus.d_gnt;
    obs_fv = bus.f_valid; obs_dv = bus.d_valid;
    obs_frd = bus.f_rdata; obs_drd = bus.d_rdata;
    obs_maddr = bus.mem_addr; obs_mwd = bus.mem_wdata; obs_we = bus.mem_we;
    if (!reset_n) begin
      check("rst_f_gnt", obs_fg, 0);
      check("rst_d_gnt", obs_dg, 0);
      check("rst_f_valid", obs_fv, 0);
      check("rst_d_valid", obs_dv, 0);
      check("rst_mem_we", obs_we, 0);
      check("rst_mem_addr", obs_maddr, 0);
      check("rst_mem_wdata", obs_mwd, 0);
      check("rst_f_rdata", obs_frd, 0);
      check("rst_d_rdata", obs_drd, 0);
      s1_v = 1'b0; s2_v = 1'b0; cnt = 0;
      f_rd = '0; d_rd = '0; last_addr = '0;
      last_fg = 1'b0; last_dg = 1'b0;
    end else begin
      // fetch wins when it may go and either data is absent or fetch is starved
      fw     = bus.f_req && !bus.halt;
      exp_fg = fw && (!bus.d_req || cnt == LIMIT);
      exp_dg = bus.d_req && !exp_fg;
      check("f_gnt", obs_fg, exp_fg);
      check("d_gnt", obs_dg, exp_dg);
      check("mem_we", obs_we, s1_v && !s1_f && s1_we);
      check("mem_addr", obs_maddr, last_addr);
      check("f_valid", obs_fv, s2_v && s2_f);
      check("d_valid", obs_dv, s2_v && !s2_f);
      check("f_rdata", obs_frd, f_rd);
      check("d_rdata", obs_drd, d_rd);
      if (obs_we) begin
        we_cycles++;
        mem[bus.mem_addr] = bus.mem_wdata;
      end
      if (exp_fg) $display("t=%0t fetch grant addr=%0d", $time, bus.f_addr);
      if (exp_dg) $display("t=%0t data grant %s addr=%0d wdata=%0h", $time,
                           bus.d_we ? "store" : "load", bus.d_addr, bus.d_wdata);
      // the in-flight access finishes at the end of this cycle
      if (s1_v) begin
        if (s1_f) f_rd = ref_mem[s1_a];
        else if (s1_we) ref_mem[s1_a] = s1_wd;
        else d_rd = ref_mem[s1_a];
      end
      s2_v = s1_v; s2_f = s1_f;
      s1_v  = exp_fg || exp_dg;
      s1_f  = exp_fg;
      s1_a  = exp_fg ? bus.f_addr : bus.d_addr;
      s1_we = exp_dg && bus.d_we;
      s1_wd = bus.d_wdata;
      if (s1_v) last_addr = s1_a;
      if (exp_fg || !bus.f_req) cnt = 0;
      else if (exp_dg && cnt < LIMIT) cnt++;
      last_fg = exp_fg; last_dg = exp_dg;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.f_req = 1'b0; bus.f_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.halt = 1'b0;
  endtask

  initial begin
    int we_base;
    logic [9:0] v;
    for (int i = 0; i < 1024; i++) begin
      v = 10'($urandom);
      mem[i] = v;
      ref_mem[i] = v;
    end
    mem[5] = 10'h350;    ref_mem[5] = 10'h350;
    mem[1022] = 10'h2AA; ref_mem[1022] = 10'h2AA;
    mem[1023] = 10'h155; ref_mem[1023] = 10'h155;
    idle_inputs();

    // reset state, including a request present while reset is held
    bus.f_req = 1'b1; bus.f_addr = 10'd9;
    step();
    step();
    bus.f_req = 1'b0;
    reset_n = 1'b1;

    // fetch-only from address 5
    bus.f_req = 1'b1; bus.f_addr = 10'd5;
    step();
    check("fo_gnt_N", obs_fg, 1);
    bus.f_req = 1'b0;
    step();
    check("fo_addr_N1", obs_maddr, 10'd5);
    step();
    check("fo_valid_N2", obs_fv, 1);
    check("fo_rdata_N2", obs_frd, 10'h350);

    // store 0x1F3 to address 2, then load it back
    we_base = we_cycles;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 10'd2; bus.d_wdata = 10'h1F3;
    step();
    check("st_gnt", obs_dg, 1);
    bus.d_we = 1'b0; bus.d_wdata = 10'h000;
    step();
    check("st_we_cycle", obs_we, 1);
    bus.d_req = 1'b0;
    step();
    check("st_valid", obs_dv, 1);
    step();
    check("ld_valid", obs_dv, 1);
    check("ld_rdata", obs_drd, 10'h1F3);
    step();
    check("st_we_count", we_cycles - we_base, 1);

    // starvation: both held high -> D D D F repeating
    bus.f_req = 1'b1; bus.f_addr = 10'd40;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 10'd41;
    for (int i = 0; i < 12; i++) begin
      step();
      check("starve_f", obs_fg, (i % 4) == 3);
      check("starve_d", obs_dg, (i % 4) != 3);
    end
    idle_inputs();
    step();
    step();

    // halt: fetch is blocked for 10 cycles, granted as soon as halt drops
    bus.halt = 1'b1; bus.f_req = 1'b1; bus.f_addr = 10'd77;
    for (int i = 0; i < 10; i++) begin
      step();
      check("halt_no_fgnt", obs_fg, 0);
    end
    bus.halt = 1'b0;
    step();
    check("halt_release_fgnt", obs_fg, 1);
    idle_inputs();
    step();
    step();

    // reset during the access cycle of a fetch
    bus.f_req = 1'b1; bus.f_addr = 10'd7;
    step();
    check("rm_gnt", obs_fg, 1);
    bus.f_req = 1'b0;
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rm_no_valid", obs_fv, 0);
    end

    // boundary: back-to-back fetches to 1022 and 1023
    bus.f_req = 1'b1; bus.f_addr = 10'd1022;
    step();
    bus.f_addr = 10'd1023;
    step();
    check("bd_gnt2", obs_fg, 1);
    bus.f_req = 1'b0;
    step();
    check("bd_valid1", obs_fv, 1);
    check("bd_rdata1", obs_frd, 10'h2AA);
    step();
    check("bd_valid2", obs_fv, 1);
    check("bd_rdata2", obs_frd, 10'h155);
    check("bd_addr", obs_maddr, 10'd1023);
    step();

    // random traffic; requesters hold their request until granted
    for (int i = 0; i < 400; i++) begin
      if (!bus.f_req || last_fg) begin
        bus.f_req  = ($urandom_range(0, 2) != 0);
        bus.f_addr = 10'($urandom);
      end
      if (!bus.d_req || last_dg) begin
        bus.d_req   = ($urandom_range(0, 2) != 0);
        bus.d_we    = $urandom_range(0, 1) == 1;
        bus.d_addr  = 10'($urandom_range(0, 15));
        bus.d_wdata = 10'($urandom);
      end
      bus.halt = ($urandom_range(0, 7) == 0);
      step();
    end
    idle_inputs();
    for (int i = 0; i < 4; i++) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
